// File: rtl/ahb_lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb_lite_pkg
// Shared AHB-Lite encodings and the burst sequencer state type.
//   htrans_t     : HTRANS transfer type encodings
//   HBURST_*     : burst type encodings used by the write sequencer
//   HSIZE_WORD   : 32-bit transfer size
//   seq_state_t  : states of the burst write sequencer FSM
// ---------------------------------------------------------------------------
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR0,
        S_BURST,
        S_LAST,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/ahb_beat_counter.sv
// ---------------------------------------------------------------------------
// ahb_beat_counter
// Address-phase and data-phase beat counters for one AHB burst.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart both counters at zero (block accepted)
//   hready   : slave ready; counters only move on completed phases
//   a_en     : an address phase is in progress
//   d_en     : a data phase is in progress
//   a_cnt    : index of the beat currently in its address phase
//   a_last   : address phase of the final beat is on the bus
//   d_last   : data phase of the final beat is on the bus
// ---------------------------------------------------------------------------
module ahb_beat_counter #(
    parameter int BEATS = 4,
    parameter int CNT_W = $clog2(BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hready,
    input  logic             a_en,
    input  logic             d_en,
    output logic [CNT_W-1:0] a_cnt,
    output logic             a_last,
    output logic             d_last
);

    logic [CNT_W-1:0] d_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt <= '0;
            d_cnt <= '0;
        end else if (clear) begin
            a_cnt <= '0;
            d_cnt <= '0;
        end else begin
            if (a_en && hready) begin
                a_cnt <= a_cnt + 1'b1;
            end
            if (d_en && hready) begin
                d_cnt <= d_cnt + 1'b1;
            end
        end
    end

    assign a_last = (a_cnt == CNT_W'(BEATS - 1));
    assign d_last = (d_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/ahb_burst_write_sequencer.sv
// ---------------------------------------------------------------------------
// ahb_burst_write_sequencer
// Takes one ciphertext block plus a destination address and writes it to the
// AHB-Lite fabric as a single INCR4 burst, most significant word first.
// The destination advances by one block after every successful burst.
//   HCLK, HRESET      : clock, asynchronous active-high reset
//   dest_addr         : destination byte address (aligned down to 16 bytes)
//   dest_updated      : pulse, load dest_addr
//   text_in           : ciphertext block, BEATS*DATA_W bits
//   text_valid        : text_in valid
//   text_ready        : block accepted when text_valid & text_ready
//   HREADY, HRESP     : slave ready and error response
//   HADDR, HWRITE,
//   HSIZE, HBURST,
//   HTRANS, HWDATA    : AHB-Lite master outputs
//   busy              : burst in progress
//   done              : pulse, burst completed without error
//   err               : pulse, burst aborted by an error response
// ---------------------------------------------------------------------------
module ahb_burst_write_sequencer
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [ADDR_W-1:0]       dest_addr,
    input  logic                    dest_updated,
    input  logic [BEATS*DATA_W-1:0] text_in,
    input  logic                    text_valid,
    output logic                    text_ready,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic [ADDR_W-1:0]       HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [1:0]              HTRANS,
    output logic [DATA_W-1:0]       HWDATA,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int CNT_W      = $clog2(BEATS + 1);
    localparam int BEAT_BYTES = DATA_W / 8;
    localparam int BLK_BYTES  = BEATS * BEAT_BYTES;
    // Block alignment keeps every burst inside a single 1 KB region.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(15);

    seq_state_t              state, state_n;
    htrans_t                 htrans_q, htrans_n;
    logic [ADDR_W-1:0]       haddr_n;
    logic                    hwrite_n;
    logic [2:0]              hburst_n;
    logic [DATA_W-1:0]       hwdata_n;
    logic                    done_n, err_n;
    logic                    accept, a_en, d_en;
    logic                    addr_valid, addr_valid_n;
    logic [ADDR_W-1:0]       dest_reg, base_reg;
    logic [BEATS*DATA_W-1:0] text_reg;
    logic [CNT_W-1:0]        a_cnt;
    logic                    a_last, d_last;
    int                      beat_idx;

    ahb_beat_counter #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_beat_counter (
        .clk    (HCLK),
        .rst    (HRESET),
        .clear  (accept),
        .hready (HREADY),
        .a_en   (a_en),
        .d_en   (d_en),
        .a_cnt  (a_cnt),
        .a_last (a_last),
        .d_last (d_last)
    );

    assign addr_valid_n = addr_valid | dest_updated;

    // Bus outputs are registered: each value computed here is what the bus
    // shows in the state being entered. Defaults hold everything, which is
    // exactly the wait-state behaviour.
    always_comb begin
        state_n  = state;
        htrans_n = htrans_q;
        haddr_n  = HADDR;
        hwrite_n = HWRITE;
        hburst_n = HBURST;
        hwdata_n = HWDATA;
        done_n   = 1'b0;
        err_n    = 1'b0;
        accept   = 1'b0;
        a_en     = 1'b0;
        d_en     = 1'b0;
        // Beat a_cnt carries the word counted from the MSW end.
        beat_idx = BEATS - 1 - int'(a_cnt);

        case (state)
            S_IDLE: begin
                if (text_valid && text_ready) begin
                    accept   = 1'b1;
                    state_n  = S_ADDR0;
                    htrans_n = HTRANS_NONSEQ;
                    haddr_n  = dest_reg;
                    hwrite_n = 1'b1;
                    hburst_n = HBURST_INCR4;
                end
            end
            S_ADDR0: begin
                a_en = 1'b1;
                if (HREADY) begin
                    state_n  = S_BURST;
                    htrans_n = HTRANS_SEQ;
                    haddr_n  = base_reg + ADDR_W'(BEAT_BYTES);
                    hwdata_n = text_reg[beat_idx*DATA_W +: DATA_W];
                end
            end
            S_BURST: begin
                if (HRESP && !HREADY) begin
                    state_n  = S_ERR;
                    htrans_n = HTRANS_IDLE;
                    hwrite_n = 1'b0;
                end else begin
                    a_en = 1'b1;
                    d_en = 1'b1;
                    if (HREADY) begin
                        hwdata_n = text_reg[beat_idx*DATA_W +: DATA_W];
                        if (a_last) begin
                            state_n  = S_LAST;
                            htrans_n = HTRANS_IDLE;
                            hwrite_n = 1'b0;
                        end else begin
                            haddr_n = base_reg + ADDR_W'((int'(a_cnt) + 1) * BEAT_BYTES);
                        end
                    end
                end
            end
            S_LAST: begin
                if (HRESP && !HREADY) begin
                    state_n = S_ERR;
                end else if (HREADY && d_last) begin
                    state_n  = S_IDLE;
                    hburst_n = HBURST_SINGLE;
                    done_n   = 1'b1;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    state_n  = S_IDLE;
                    hburst_n = HBURST_SINGLE;
                    err_n    = 1'b1;
                end
            end
            default: begin
                state_n  = S_IDLE;
                htrans_n = HTRANS_IDLE;
                hwrite_n = 1'b0;
                hburst_n = HBURST_SINGLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= S_IDLE;
            htrans_q   <= HTRANS_IDLE;
            HADDR      <= '0;
            HWRITE     <= 1'b0;
            HBURST     <= HBURST_SINGLE;
            HWDATA     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            text_ready <= 1'b0;
            addr_valid <= 1'b0;
            dest_reg   <= '0;
            base_reg   <= '0;
            text_reg   <= '0;
        end else begin
            state      <= state_n;
            htrans_q   <= htrans_n;
            HADDR      <= haddr_n;
            HWRITE     <= hwrite_n;
            HBURST     <= hburst_n;
            HWDATA     <= hwdata_n;
            done       <= done_n;
            err        <= err_n;
            addr_valid <= addr_valid_n;
            // Ready is registered but looks ahead at the next state, so the
            // cycle after a burst completes can already accept a block.
            text_ready <= (state_n == S_IDLE) && addr_valid_n;
            if (accept) begin
                text_reg <= text_in;
                base_reg <= dest_reg;
            end
            // A fresh destination beats the post-burst auto-advance.
            if (dest_updated) begin
                dest_reg <= dest_addr & ALIGN_MASK;
            end else if (done_n) begin
                dest_reg <= dest_reg + ADDR_W'(BLK_BYTES);
            end
        end
    end

    assign HTRANS = htrans_q;
    assign HSIZE  = HSIZE_WORD;
    assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_ahb_burst_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ahb_burst_write_sequencer
// Directed bench for ahb_burst_write_sequencer with hand-computed bus values.
// Inputs are applied just after each rising edge; outputs are checked 1 ns
// after the edge, once the registered outputs have settled.
// ---------------------------------------------------------------------------
module tb_ahb_burst_write_sequencer;
    import ahb_lite_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BEATS  = 4;

    localparam logic [127:0] T1 = 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD;
    localparam logic [127:0] T2 = 128'h1111_1111_2222_2222_3333_3333_4444_4444;
    localparam logic [127:0] T3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] T4 = 128'hCAFE_0000_CAFE_0001_CAFE_0002_CAFE_0003;

    logic                    tb_HCLK = 1'b0;
    logic                    HRESET;
    logic [ADDR_W-1:0]       dest_addr;
    logic                    dest_updated;
    logic [BEATS*DATA_W-1:0] text_in;
    logic                    text_valid;
    logic                    text_ready;
    logic                    HREADY;
    logic                    HRESP;
    logic [ADDR_W-1:0]       HADDR;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [2:0]              HBURST;
    logic [1:0]              HTRANS;
    logic [DATA_W-1:0]       HWDATA;
    logic                    busy;
    logic                    done;
    logic                    err;

    int testCount = 0;
    int failCount = 0;

    always #5 tb_HCLK = ~tb_HCLK;

    ahb_burst_write_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) dut (
        .HCLK         (tb_HCLK),
        .HRESET       (HRESET),
        .dest_addr    (dest_addr),
        .dest_updated (dest_updated),
        .text_in      (text_in),
        .text_valid   (text_valid),
        .text_ready   (text_ready),
        .HREADY       (HREADY),
        .HRESP        (HRESP),
        .HADDR        (HADDR),
        .HWRITE       (HWRITE),
        .HSIZE        (HSIZE),
        .HBURST       (HBURST),
        .HTRANS       (HTRANS),
        .HWDATA       (HWDATA),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives the slave response for the current cycle and advances one clock.
    task automatic applyStimulus(input logic hready, input logic hresp);
        HREADY = hready;
        HRESP  = hresp;
        @(posedge tb_HCLK);
        #1;
    endtask

    task automatic checkBeat(input string tag, input logic [1:0] trans,
                             input logic [31:0] addr, input logic [31:0] data);
        checkOutput({tag, ".htrans"}, 64'(HTRANS), 64'(trans));
        checkOutput({tag, ".haddr"},  64'(HADDR),  64'(addr));
        checkOutput({tag, ".hwdata"}, 64'(HWDATA), 64'(data));
    endtask

    initial begin
        HRESET       = 1'b1;
        HREADY       = 1'b1;
        HRESP        = 1'b0;
        dest_addr    = '0;
        dest_updated = 1'b0;
        text_in      = '0;
        text_valid   = 1'b0;

        repeat (2) @(posedge tb_HCLK);
        #1;
        checkOutput("rst.htrans", 64'(HTRANS), 64'(2'b00));
        checkOutput("rst.hwrite", 64'(HWRITE), 64'(0));
        checkOutput("rst.hsize",  64'(HSIZE),  64'(3'b010));
        checkOutput("rst.hburst", 64'(HBURST), 64'(3'b000));
        checkOutput("rst.haddr",  64'(HADDR),  64'(0));
        checkOutput("rst.hwdata", 64'(HWDATA), 64'(0));
        checkOutput("rst.ready",  64'(text_ready), 64'(0));
        checkOutput("rst.busy",   64'(busy), 64'(0));
        checkOutput("rst.done",   64'(done), 64'(0));
        checkOutput("rst.err",    64'(err),  64'(0));
        HRESET = 1'b0;

        // Block offered before any destination is known: never accepted.
        text_valid = 1'b1;
        text_in    = T1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("noaddr.ready",  64'(text_ready), 64'(0));
            checkOutput("noaddr.htrans", 64'(HTRANS), 64'(2'b00));
            checkOutput("noaddr.busy",   64'(busy), 64'(0));
        end

        // Load 0x1008, which aligns down to 0x1000.
        dest_addr    = 32'h0000_1008;
        dest_updated = 1'b1;
        applyStimulus(1'b1, 1'b0);
        dest_updated = 1'b0;
        dest_addr    = '0;
        checkOutput("load.ready",  64'(text_ready), 64'(1));
        checkOutput("load.htrans", 64'(HTRANS), 64'(2'b00));

        // Zero-wait burst of T1.
        applyStimulus(1'b1, 1'b0);
        checkOutput("b1.nonseq", 64'(HTRANS), 64'(HTRANS_NONSEQ));
        checkOutput("b1.haddr0", 64'(HADDR),  64'(32'h0000_1000));
        checkOutput("b1.hwrite", 64'(HWRITE), 64'(1));
        checkOutput("b1.hburst", 64'(HBURST), 64'(3'b011));
        checkOutput("b1.hsize",  64'(HSIZE),  64'(3'b010));
        checkOutput("b1.busy",   64'(busy), 64'(1));
        checkOutput("b1.ready",  64'(text_ready), 64'(0));
        text_in = T2;
        applyStimulus(1'b1, 1'b0);
        checkBeat("b1.beat1", HTRANS_SEQ, 32'h0000_1004, 32'hAAAA_AAAA);
        applyStimulus(1'b1, 1'b0);
        checkBeat("b1.beat2", HTRANS_SEQ, 32'h0000_1008, 32'hBBBB_BBBB);
        applyStimulus(1'b1, 1'b0);
        checkBeat("b1.beat3", HTRANS_SEQ, 32'h0000_100C, 32'hCCCC_CCCC);
        applyStimulus(1'b1, 1'b0);
        checkOutput("b1.last.htrans", 64'(HTRANS), 64'(2'b00));
        checkOutput("b1.last.hwdata", 64'(HWDATA), 64'(32'hDDDD_DDDD));
        checkOutput("b1.last.hwrite", 64'(HWRITE), 64'(0));
        checkOutput("b1.last.busy",   64'(busy), 64'(1));
        checkOutput("b1.last.done",   64'(done), 64'(0));
        applyStimulus(1'b1, 1'b0);
        checkOutput("b1.done",        64'(done), 64'(1));
        checkOutput("b1.done.busy",   64'(busy), 64'(0));
        checkOutput("b1.done.htrans", 64'(HTRANS), 64'(2'b00));
        checkOutput("b1.done.ready",  64'(text_ready), 64'(1));

        // text_valid was held: second burst after exactly one idle cycle.
        applyStimulus(1'b1, 1'b0);
        checkOutput("b2.nonseq", 64'(HTRANS), 64'(HTRANS_NONSEQ));
        checkOutput("b2.haddr0", 64'(HADDR),  64'(32'h0000_1010));
        checkOutput("b2.done",   64'(done), 64'(0));
        text_valid = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkBeat("b2.beat1", HTRANS_SEQ, 32'h0000_1014, 32'h1111_1111);
        applyStimulus(1'b1, 1'b0);
        checkBeat("b2.beat2", HTRANS_SEQ, 32'h0000_1018, 32'h2222_2222);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkBeat("b2.wait", HTRANS_SEQ, 32'h0000_1018, 32'h2222_2222);
            checkOutput("b2.wait.hwrite", 64'(HWRITE), 64'(1));
        end
        applyStimulus(1'b1, 1'b0);
        checkBeat("b2.beat3", HTRANS_SEQ, 32'h0000_101C, 32'h3333_3333);
        applyStimulus(1'b1, 1'b0);
        checkOutput("b2.last.hwdata", 64'(HWDATA), 64'(32'h4444_4444));
        applyStimulus(1'b1, 1'b0);
        checkOutput("b2.done", 64'(done), 64'(1));
        checkOutput("b2.err",  64'(err),  64'(0));

        // Error response on the data phase of beat 1.
        text_valid = 1'b1;
        text_in    = T3;
        applyStimulus(1'b1, 1'b0);
        checkOutput("b3.haddr0", 64'(HADDR), 64'(32'h0000_1020));
        text_valid = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkBeat("b3.beat1", HTRANS_SEQ, 32'h0000_1024, 32'h0123_4567);
        applyStimulus(1'b1, 1'b0);
        checkBeat("b3.beat2", HTRANS_SEQ, 32'h0000_1028, 32'h89AB_CDEF);
        applyStimulus(1'b0, 1'b1);
        checkOutput("b3.resp.htrans", 64'(HTRANS), 64'(2'b00));
        checkOutput("b3.resp.hwrite", 64'(HWRITE), 64'(0));
        checkOutput("b3.resp.err",    64'(err), 64'(0));
        applyStimulus(1'b1, 1'b1);
        checkOutput("b3.err",      64'(err),  64'(1));
        checkOutput("b3.err.done", 64'(done), 64'(0));
        checkOutput("b3.err.busy", 64'(busy), 64'(0));
        applyStimulus(1'b1, 1'b0);
        checkOutput("b3.err.pulse", 64'(err), 64'(0));
        checkOutput("b3.err.ready", 64'(text_ready), 64'(1));

        // Retry lands on the same address; collide a new address with done.
        text_valid = 1'b1;
        text_in    = T4;
        applyStimulus(1'b1, 1'b0);
        checkOutput("b4.haddr0", 64'(HADDR), 64'(32'h0000_1020));
        text_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
        end
        checkBeat("b4.beat3", HTRANS_SEQ, 32'h0000_102C, 32'hCAFE_0002);
        applyStimulus(1'b1, 1'b0);
        checkOutput("b4.last.hwdata", 64'(HWDATA), 64'(32'hCAFE_0003));
        dest_addr    = 32'h0000_2000;
        dest_updated = 1'b1;
        applyStimulus(1'b1, 1'b0);
        dest_updated = 1'b0;
        dest_addr    = '0;
        checkOutput("b4.done", 64'(done), 64'(1));
        text_valid = 1'b1;
        text_in    = T1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("coll.haddr0", 64'(HADDR), 64'(32'h0000_2000));
        text_valid = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkBeat("coll.beat1", HTRANS_SEQ, 32'h0000_2004, 32'hAAAA_AAAA);

        // Reset in the middle of the burst takes effect without a clock edge.
        HRESET = 1'b1;
        #2;
        checkOutput("midrst.htrans", 64'(HTRANS), 64'(2'b00));
        checkOutput("midrst.hwrite", 64'(HWRITE), 64'(0));
        checkOutput("midrst.busy",   64'(busy), 64'(0));
        checkOutput("midrst.done",   64'(done), 64'(0));
        checkOutput("midrst.haddr",  64'(HADDR), 64'(0));
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst.hold.done", 64'(done), 64'(0));
        HRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("postrst.done",   64'(done), 64'(0));
            checkOutput("postrst.htrans", 64'(HTRANS), 64'(2'b00));
            checkOutput("postrst.ready",  64'(text_ready), 64'(0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
